sar_cmp_sequencer: RTL

- Successive-approximation sequencer for the on-chip latched comparator and its trim DAC.
- Sequences one conversion: sample phase, then per-bit DAC settle, comparator strobe and bit decision, then result hand-off.
- Sits between the digital top level (start/result) and the analog comparator cell (sample, cmp_en, cmp_in, dac_code).
- Supports single-shot and continuous conversion, plus abort.

---
 rtl/sar_cmp_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sar_cmp_sequencer.sv
// Successive-approximation sequencer for the latched comparator and trim DAC.
// Runs sample, per-bit settle/strobe/decide, and result hand-off; all outputs registered.
module sar_cmp_sequencer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample,
    output logic             cmp_en,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned IW   = $clog2(WIDTH);

    localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]    IDX_TOP     = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] trial;
    logic             sample_q, cmp_en_q, valid_q, busy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        result_d = result_q;
        trial    = dac_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    dac_d   = MSB_CODE;
                    idx_d   = IDX_TOP;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DECIDE: begin
                if (!cmp_in) begin
                    trial[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    trial[idx_q - 1'b1] = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = trial;
                end
                dac_d = trial;
            end
            S_DONE: begin
                if (cont) begin
                    state_d = S_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything above, including a result captured in the last DECIDE.
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            dac_d    = '0;
            result_d = result_q;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            cmp_en_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            sample_q <= (state_d == S_SAMPLE);
            cmp_en_q <= ((state_d == S_SETTLE) && (cnt_d == '0)) || (state_d == S_DECIDE);
            valid_q  <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign sample   = sample_q;
    assign cmp_en   = cmp_en_q;
    assign dac_code = dac_q;
    assign result   = result_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule
